// File: rtl/fetch_queue.sv
// Instruction fetch queue. It issues word-aligned fetch requests, keeps a
// tag queue of in-flight PCs, and buffers returned {pc, instr} pairs in a
// FIFO that feeds IF/ID. A redirect flushes the FIFO and marks every
// in-flight request as stale so its response is dropped when it returns.

module fetch_queue_checker #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          imem_rsp_valid,
    input logic [CW-1:0] count,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] discard
);
    localparam int OW = CW + 1;

    // A response with nothing in flight is illegal; the datapath ignores it.
    a_rsp_without_request: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding != {CW{1'b0}}));

    // Buffered plus in-flight entries never exceed the queue depth.
    a_occupancy: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, count} + {1'b0, outstanding}) <= OW'(DEPTH)));

    // Stale requests are always a subset of in-flight requests.
    a_discard_bound: assert property (@(posedge clk) disable iff (rst)
        (discard <= outstanding));
endmodule

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        deq_valid,
    input  logic        deq_ready,
    output logic [31:0] deq_pc,
    output logic [31:0] deq_instr
);
    // Pointer width (DEPTH is a power of two, so pointers wrap naturally)
    // and counter width (counters span 0..DEPTH inclusive).
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    // Architectural state.
    logic [31:0]   fetch_pc_r;
    logic [31:0]   fifo_pc_r    [DEPTH];
    logic [31:0]   fifo_instr_r [DEPTH];
    logic [31:0]   tag_pc_r     [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [PW-1:0] tag_head_r;
    logic [PW-1:0] tag_tail_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] outstanding_r;
    logic [CW-1:0] discard_r;

    // Per-cycle events and next-state values.
    logic [OW-1:0] occupancy_s;
    logic          req_valid_s;
    logic          accept_s;
    logic          rsp_fire_s;
    logic          rsp_keep_s;
    logic          deq_fire_s;
    logic [CW-1:0] count_next_s;
    logic [CW-1:0] outstanding_next_s;
    logic [CW-1:0] discard_next_s;
    logic [31:0]   redirect_target_s;

    // Decode this cycle's handshakes; a redirect blocks issue and dequeue.
    always_comb begin
        occupancy_s       = {1'b0, count_r} + {1'b0, outstanding_r};
        req_valid_s       = 1'b0;
        accept_s          = 1'b0;
        rsp_fire_s        = 1'b0;
        rsp_keep_s        = 1'b0;
        deq_fire_s        = 1'b0;
        redirect_target_s = redirect_pc & 32'hFFFF_FFFC;
        if (!rst && !redirect_valid && (occupancy_s < OW'(DEPTH))) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
        accept_s = req_valid_s && imem_req_ready;
        // Responses with nothing outstanding are spurious and ignored.
        if (imem_rsp_valid && (outstanding_r != {CW{1'b0}})) begin
            rsp_fire_s = 1'b1;
        end else begin
            rsp_fire_s = 1'b0;
        end
        // A response is kept only if it is not stale and not hit by a redirect.
        rsp_keep_s = rsp_fire_s && (discard_r == {CW{1'b0}}) && !redirect_valid;
        deq_fire_s = (count_r != {CW{1'b0}}) && deq_ready && !redirect_valid;
    end

    // Counter arithmetic; on redirect every still-in-flight request goes stale.
    always_comb begin
        count_next_s       = count_r;
        outstanding_next_s = outstanding_r + CW'(accept_s) - CW'(rsp_fire_s);
        discard_next_s     = discard_r;
        if (redirect_valid) begin
            count_next_s   = {CW{1'b0}};
            discard_next_s = outstanding_r - CW'(rsp_fire_s);
        end else begin
            count_next_s = count_r + CW'(rsp_keep_s) - CW'(deq_fire_s);
            if (rsp_fire_s && (discard_r != {CW{1'b0}})) begin
                discard_next_s = discard_r - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                discard_next_s = discard_r;
            end
        end
    end

    // Control state: fetch PC, counters and queue pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            count_r       <= {CW{1'b0}};
            outstanding_r <= {CW{1'b0}};
            discard_r     <= {CW{1'b0}};
            head_r        <= {PW{1'b0}};
            tail_r        <= {PW{1'b0}};
            tag_head_r    <= {PW{1'b0}};
            tag_tail_r    <= {PW{1'b0}};
        end else begin
            count_r       <= count_next_s;
            outstanding_r <= outstanding_next_s;
            discard_r     <= discard_next_s;
            if (redirect_valid) begin
                fetch_pc_r <= redirect_target_s;
            end else if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
            // Tag queue tracks every in-flight request, stale or not.
            if (accept_s) begin
                tag_tail_r <= tag_tail_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                tag_tail_r <= tag_tail_r;
            end
            if (rsp_fire_s) begin
                tag_head_r <= tag_head_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                tag_head_r <= tag_head_r;
            end
            // Flush by collapsing head onto tail; no write happens on redirect.
            if (redirect_valid) begin
                head_r <= tail_r;
                tail_r <= tail_r;
            end else begin
                if (deq_fire_s) begin
                    head_r <= head_r + {{(PW-1){1'b0}}, 1'b1};
                end else begin
                    head_r <= head_r;
                end
                if (rsp_keep_s) begin
                    tail_r <= tail_r + {{(PW-1){1'b0}}, 1'b1};
                end else begin
                    tail_r <= tail_r;
                end
            end
        end
    end

    // Storage arrays: record issued PCs and write kept responses at the tail.
    always_ff @(posedge clk) begin
        if (!rst && accept_s) begin
            tag_pc_r[tag_tail_r] <= fetch_pc_r;
        end
        if (!rst && rsp_keep_s) begin
            fifo_pc_r[tail_r]    <= tag_pc_r[tag_head_r];
            fifo_instr_r[tail_r] <= imem_rsp_data;
        end
    end

    // Outputs come straight from state; request valid must see redirect.
    always_comb begin
        imem_req_valid = req_valid_s;
        imem_req_addr  = fetch_pc_r;
        deq_valid      = (count_r != {CW{1'b0}});
        deq_pc         = fifo_pc_r[head_r];
        deq_instr      = fifo_instr_r[head_r];
    end

    fetch_queue_checker #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_checker (
        .clk            (clk),
        .rst            (rst),
        .imem_rsp_valid (imem_rsp_valid),
        .count          (count_r),
        .outstanding    (outstanding_r),
        .discard        (discard_r)
    );
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries and maximum outstanding instruction-memory requests; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_addr  output  32  word-aligned fetch address.
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_rsp_valid  input  1  instruction word returned, strictly in request order, at least 1 cycle after acceptance.
REQ-009 imem_rsp_data  input  32  returned instruction word.
REQ-010 redirect_valid  input  1  PC redirect (ID-stage mispredict or flush), single-cycle pulse.
REQ-011 redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-012 deq_valid  output  1  head entry valid, feeding IF/ID.
REQ-013 deq_ready  input  1  IF/ID write enable (~stall); dequeue when deq_valid && deq_ready.
REQ-014 deq_pc  output  32  PC of head entry.
REQ-015 deq_instr  output  32  instruction of head entry.

Function
REQ-016 State: fetch_pc, FIFO of {pc, instr} with count 0..DEPTH, outstanding counter 0..DEPTH, discard counter 0..DEPTH.
REQ-017 imem_req_valid = !redirect_valid && (count + outstanding < DEPTH); imem_req_addr = fetch_pc.
REQ-018 Request accepted (valid && ready): fetch_pc += 4 modulo 2^32; outstanding += 1; the request's PC is pushed to an in-order PC tag queue.
REQ-019 Response with discard > 0: word dropped, discard -= 1, outstanding -= 1, tag popped.
REQ-020 Response with discard == 0: {tag pc, data} written to FIFO tail, outstanding -= 1, count += 1; visible at deq outputs no earlier than the next cycle (no bypass).
REQ-021 Dequeue: head advances, count -= 1; deq_pc/deq_instr are driven directly from the head entry; content is don't-care when deq_valid = 0.
REQ-022 Accept, response and dequeue in the same cycle all take effect; counters net correctly.
REQ-023 Redirect cycle: FIFO emptied (count <= 0); fetch_pc <= redirect_pc; discard <= outstanding after any same-cycle response is retired; that same-cycle response is dropped; any dequeue that cycle is ignored; no request is issued.
REQ-024 Redirect while discard > 0: discard recomputed per REQ-023, giving the total stale in-flight count.
REQ-025 First request after redirect: next cycle at redirect_pc; requests may issue while discard > 0.
REQ-026 deq_valid = (count > 0); it never reflects an entry older than the last redirect.
REQ-027 Response with outstanding == 0 is illegal; it is ignored and flagged by a simulation assertion.
REQ-028 Full (count == DEPTH) with deq_ready = 0: no requests, entries held stable, no loss.
REQ-029 Throughput: with 1-cycle memory latency, always-ready memory and always-ready consumer, one instruction is dequeued per cycle in steady state.

Reset
REQ-030 While rst = 1: fetch_pc <= RESET_PC; count, outstanding and discard <= 0; imem_req_valid = 0; deq_valid = 0.
REQ-031 rst overrides redirect and in-flight responses; responses arriving during or after reset for pre-reset requests are not required to be handled (the bench quiesces memory).
REQ-032 First cycle after rst deasserts: imem_req_valid = 1, imem_req_addr = RESET_PC.

Verification
REQ-033 Reset release with 1-cycle memory and deq_ready = 1 -> deq_pc sequence 0x0, 0x4, 0x8, ...; first deq_valid on cycle 2 after release; then one per cycle.
REQ-034 DEPTH = 4, deq_ready = 0 -> exactly 4 requests (0x0..0xC); imem_req_valid low afterwards; count = 4; release -> entries in order and fetching resumes at 0x10.
REQ-035 3-cycle memory latency with 3 outstanding, redirect to 0x100 -> the 3 stale responses are dropped; first deq_pc = 0x100; no entry below 0x100 is dequeued.
REQ-036 Redirect to 0x200 in the same cycle as a response and a dequeue -> response dropped, dequeue ignored, deq_valid = 0 next cycle, next request address 0x200.
REQ-037 Back-to-back redirects to 0x40 then 0x80 with responses outstanding -> only 0x80-stream instructions are dequeued.
REQ-038 Random memory-ready and latency, random deq_ready and redirects -> scoreboard confirms in-order, loss-free delivery of PC/instruction pairs, pc + 4 sequencing between redirects, and count + outstanding <= DEPTH always.
